// File: rtl/sobol_rng_multi_pkg.sv
// Shared definitions for the Sobol RNG family: default direction vectors and index-width helpers.
package sobol_rng_multi_pkg;

    localparam int unsigned SOBOL_MAX_BITWIDTH = 64;

    // Van der Corput default: vector k carries a single bit at position BITWIDTH-1-k.
    function automatic logic [63:0] dv_default(input int k, input int bw);
        return 64'd1 << (bw - 1 - k);
    endfunction

    // Width of an index that addresses bw positions; never narrower than one bit.
    function automatic int lsz_width(input int bw);
        return (bw > 1) ? $clog2(bw) : 1;
    endfunction

endpackage

// File: rtl/sobol_rng_multi_chk.sv
// Structural invariants of the Sobol generator, kept apart from the datapath.
module sobol_rng_multi_chk #(
    parameter int BITWIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    input logic                en,
    input logic                clr,
    input logic [BITWIDTH-1:0] cnt,
    input logic                lsz_valid,
    input logic                wrap
);

    // A wrap pulse always coincides with the counter back at zero.
    a_wrap_at_zero: assert property (@(posedge clk) disable iff (rst) wrap |-> (cnt == {BITWIDTH{1'b0}}));

    // The encoder only loses its valid flag on the all-ones counter value.
    a_lsz_valid: assert property (@(posedge clk) disable iff (rst) lsz_valid == ~(&cnt));

    // Advancing from the last index must raise the wrap pulse on the next cycle.
    a_wrap_follows: assert property (@(posedge clk) disable iff (rst) (en && !clr && !lsz_valid) |=> wrap);

endmodule

// File: rtl/sobol_rng_multi_lsz_enc.sv
// Generic-width least-significant-zero encoder; valid drops when the input is all ones.
module lsz_enc
    import sobol_rng_multi_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = lsz_width(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0]    din,
    output logic [LOGBITWIDTH-1:0] idx,
    output logic                   valid
);

    // Priority scan from bit 0 upward; the first zero found is latched and later bits are ignored.
    always_comb begin
        idx   = {LOGBITWIDTH{1'b0}};
        valid = 1'b0;
        for (int i = 0; i < BITWIDTH; i++) begin
            idx   = (!din[i] && !valid) ? LOGBITWIDTH'(i) : idx;
            valid = valid | ~din[i];
        end
    end

endmodule

// File: rtl/sobol_rng_multi.sv
// Multi-channel Sobol sequence generator: shared counter, LSZ-selected direction vectors, XOR state per channel.
module sobol_rng_multi
    import sobol_rng_multi_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int CHANNELS    = 2,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH),
    parameter int LOGCH       = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iEn,
    input  logic                         iClr,
    input  logic                         iDvWe,
    input  logic [LOGCH-1:0]             iDvCh,
    input  logic [LOGBITWIDTH-1:0]       iDvIdx,
    input  logic [BITWIDTH-1:0]          iDvData,
    output logic [CHANNELS*BITWIDTH-1:0] oRand,
    output logic [BITWIDTH-1:0]          oIdx,
    output logic                         oWrap
);

    logic [BITWIDTH-1:0]    cnt_r;
    logic [BITWIDTH-1:0]    cnt_nxt_s;
    logic [BITWIDTH-1:0]    state_r     [CHANNELS];
    logic [BITWIDTH-1:0]    state_nxt_s [CHANNELS];
    logic [BITWIDTH-1:0]    dv_r        [CHANNELS][BITWIDTH];
    logic [BITWIDTH-1:0]    dv_init_s   [BITWIDTH];
    logic                   wrap_r;
    logic                   wrap_nxt_s;
    logic [LOGBITWIDTH-1:0] lsz_idx_s;
    logic                   lsz_valid_s;
    logic                   idx_in_range_s;
    logic                   ch_in_range_s;
    logic                   dv_wr_ok_s;

    for (genvar k = 0; k < BITWIDTH; k++) begin : g_dv_init
        assign dv_init_s[k] = BITWIDTH'(dv_default(k, BITWIDTH));
    end

    lsz_enc #(
        .BITWIDTH    (BITWIDTH),
        .LOGBITWIDTH (LOGBITWIDTH)
    ) u_lsz (
        .din   (cnt_r),
        .idx   (lsz_idx_s),
        .valid (lsz_valid_s)
    );

    // Table write qualification: index and channel must address a real entry.
    always_comb begin
        idx_in_range_s = (32'(iDvIdx) < 32'(BITWIDTH));
        ch_in_range_s  = (32'(iDvCh) < 32'(CHANNELS));
        dv_wr_ok_s     = 1'b0;
        if (iDvWe && idx_in_range_s && ch_in_range_s) begin
            dv_wr_ok_s = 1'b1;
        end else begin
            dv_wr_ok_s = 1'b0;
        end
    end

    // Sequence step: clear beats advance; an advance with no LSZ restarts the period and flags the wrap.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        wrap_nxt_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_nxt_s[c] = state_r[c];
        end
        if (iClr) begin
            cnt_nxt_s = {BITWIDTH{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                state_nxt_s[c] = {BITWIDTH{1'b0}};
            end
        end else if (iEn) begin
            if (lsz_valid_s) begin
                cnt_nxt_s = cnt_r + {{(BITWIDTH-1){1'b0}}, 1'b1};
                for (int c = 0; c < CHANNELS; c++) begin
                    state_nxt_s[c] = state_r[c] ^ dv_r[c][lsz_idx_s];
                end
            end else begin
                cnt_nxt_s  = {BITWIDTH{1'b0}};
                wrap_nxt_s = 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    state_nxt_s[c] = {BITWIDTH{1'b0}};
                end
            end
        end else begin
            cnt_nxt_s  = cnt_r;
            wrap_nxt_s = 1'b0;
        end
    end

    // Counter, channel states and wrap pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {BITWIDTH{1'b0}};
            wrap_r <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= {BITWIDTH{1'b0}};
            end
        end else begin
            cnt_r  <= cnt_nxt_s;
            wrap_r <= wrap_nxt_s;
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= state_nxt_s[c];
            end
        end
    end

    // Direction table; the advance above reads the pre-write entry because the write lands at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < BITWIDTH; k++) begin
                    dv_r[c][k] <= dv_init_s[k];
                end
            end
        end else if (dv_wr_ok_s) begin
            dv_r[iDvCh][iDvIdx] <= iDvData;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign oRand[c*BITWIDTH +: BITWIDTH] = state_r[c];
    end
    assign oIdx  = cnt_r;
    assign oWrap = wrap_r;

    sobol_rng_multi_chk #(
        .BITWIDTH (BITWIDTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .en        (iEn),
        .clr       (iClr),
        .cnt       (cnt_r),
        .lsz_valid (lsz_valid_s),
        .wrap      (wrap_r)
    );

endmodule

// File: tb/tb_sobol_rng_multi.sv
// Self-checking bench: vector table, directed corner sequences and a random run against a Sobol reference model.
module tb_sobol_rng_multi;

    localparam int BW   = 4;
    localparam int NCH  = 2;
    localparam int BBW  = 12;
    localparam int BNCH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, iEn = 1'b0, iClr = 1'b0, iDvWe = 1'b0;
    logic [0:0]  iDvCh = 1'b0;
    logic [1:0]  iDvIdx = 2'd0;
    logic [3:0]  iDvData = 4'd0;
    logic [7:0]  oRand;
    logic [3:0]  oIdx;
    logic        oWrap;

    logic        b_rst = 1'b1, b_en = 1'b0, b_clr = 1'b0, b_we = 1'b0;
    logic [1:0]  b_ch = 2'd0;
    logic [3:0]  b_idx = 4'd0;
    logic [11:0] b_data = 12'd0;
    logic [35:0] b_rand;
    logic [11:0] b_oidx;
    logic        b_wrap;

    sobol_rng_multi #(.BITWIDTH(BW), .CHANNELS(NCH)) u_dut (
        .clk(clk), .rst(rst), .iEn(iEn), .iClr(iClr), .iDvWe(iDvWe), .iDvCh(iDvCh),
        .iDvIdx(iDvIdx), .iDvData(iDvData), .oRand(oRand), .oIdx(oIdx), .oWrap(oWrap)
    );

    sobol_rng_multi #(.BITWIDTH(BBW), .CHANNELS(BNCH)) u_big (
        .clk(clk), .rst(b_rst), .iEn(b_en), .iClr(b_clr), .iDvWe(b_we), .iDvCh(b_ch),
        .iDvIdx(b_idx), .iDvData(b_data), .oRand(b_rand), .oIdx(b_oidx), .oWrap(b_wrap)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: sequence index, per-channel sample and direction table as plain integers.
    int m_n;
    int m_wrap;
    int m_st [NCH];
    int m_dv [NCH][BW];

    task automatic model_step(input bit r, input bit c, input bit e, input bit w,
                              input int ch, input int ix, input int d);
        int k;
        if (r) begin
            m_n = 0;
            m_wrap = 0;
            for (int i = 0; i < NCH; i++) begin
                m_st[i] = 0;
                for (int j = 0; j < BW; j++) m_dv[i][j] = 1 << (BW - 1 - j);
            end
        end else begin
            if (c) begin
                m_n = 0;
                m_wrap = 0;
                for (int i = 0; i < NCH; i++) m_st[i] = 0;
            end else if (e) begin
                if (m_n == (1 << BW) - 1) begin
                    m_n = 0;
                    m_wrap = 1;
                    for (int i = 0; i < NCH; i++) m_st[i] = 0;
                end else begin
                    // n ^ (n+1) is a run of k+1 ones, k being the least-significant zero of n.
                    k = $clog2((m_n ^ (m_n + 1)) + 1) - 1;
                    for (int i = 0; i < NCH; i++) m_st[i] = m_st[i] ^ m_dv[i][k];
                    m_n = m_n + 1;
                    m_wrap = 0;
                end
            end else begin
                m_wrap = 0;
            end
            if (w && ix < BW && ch < NCH) m_dv[ch][ix] = d;
        end
    endtask

    task automatic apply(input bit r, input bit c, input bit e, input bit w,
                         input int ch, input int ix, input int d);
        rst = r; iClr = c; iEn = e; iDvWe = w;
        iDvCh = ch[0:0]; iDvIdx = ix[1:0]; iDvData = d[3:0];
        @(posedge clk);
        #1;
        model_step(r, c, e, w, ch, ix, d);
        check("mdl_ch0", oRand[3:0], m_st[0]);
        check("mdl_ch1", oRand[7:4], m_st[1]);
        check("mdl_idx", oIdx, m_n);
        check("mdl_wrap", oWrap, m_wrap);
    endtask

    typedef struct {
        bit e; bit c; bit w;
        int ch; int ix; int d;
        int e0; int e1; int eidx; int ewrap;
    } vec_t;

    function automatic vec_t mk(bit e, bit c, bit w, int ch, int ix, int d,
                                int e0, int e1, int eidx, int ewrap);
        vec_t v;
        v.e = e; v.c = c; v.w = w; v.ch = ch; v.ix = ix; v.d = d;
        v.e0 = e0; v.e1 = e1; v.eidx = eidx; v.ewrap = ewrap;
        return v;
    endfunction

    // Big instance: closed-form Sobol via Gray code of n.
    int bdv [BNCH][BBW];

    function automatic int gx(int c, int n);
        int g;
        int x;
        g = n ^ (n >> 1);
        x = 0;
        for (int j = 0; j < BBW; j++) if (((g >> j) & 1) == 1) x = x ^ bdv[c][j];
        return x;
    endfunction

    task automatic bdrive(input bit r, input bit e, input bit w, input int ch, input int ix, input int d);
        b_rst = r; b_en = e; b_we = w; b_clr = 1'b0;
        b_ch = ch[1:0]; b_idx = ix[3:0]; b_data = d[11:0];
        @(posedge clk);
        #1;
        if (!r && w && ix < BBW && ch < BNCH) bdv[ch][ix] = d;
    endtask

    initial begin
        vec_t tbl[$];
        int   seq0[8];
        int   seq1[8];
        int   dv1[4];
        int   got[$];
        bit   seen[16];
        int   nseen;
        int   wraps;
        int   rr, rc, re, rw;

        seq0 = '{8, 12, 4, 6, 14, 10, 2, 3};
        seq1 = '{8, 4, 12, 6, 14, 2, 10, 5};
        dv1  = '{8, 12, 10, 15};

        // Reset state
        apply(1, 0, 0, 0, 0, 0, 0);
        check("rst_rand", oRand, 0);
        check("rst_idx", oIdx, 0);
        check("rst_wrap", oWrap, 0);
        apply(0, 0, 0, 0, 0, 0, 0);

        // Default-table run, ch1 reload, clear, then the reloaded run
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, seq0[i], seq0[i], i + 1, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 1, 1, k, dv1[k], 3, 3, 8, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, seq0[i], seq1[i], i + 1, 0));
        foreach (tbl[i]) begin
            apply(0, tbl[i].c, tbl[i].e, tbl[i].w, tbl[i].ch, tbl[i].ix, tbl[i].d);
            check("tbl_ch0", oRand[3:0], tbl[i].e0);
            check("tbl_ch1", oRand[7:4], tbl[i].e1);
            check("tbl_idx", oIdx, tbl[i].eidx);
            check("tbl_wrap", oWrap, tbl[i].ewrap);
        end

        // Full period: single wrap, zero sample on wrap, every value once
        apply(1, 0, 0, 0, 0, 0, 0);
        foreach (seen[i]) seen[i] = 1'b0;
        seen[oRand[3:0]] = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 1, 0, 0, 0, 0);
            if (oWrap) wraps++;
            if (i < 16) seen[oRand[3:0]] = 1'b1;
            if (i == 16) begin
                check("period_wrap", oWrap, 1);
                check("period_idx0", oIdx, 0);
                check("period_rand0", oRand, 0);
            end
        end
        check("period_wrap_count", wraps, 1);
        nseen = 0;
        foreach (seen[i]) if (seen[i]) nseen++;
        check("period_distinct", nseen, 16);

        // Random enable gaps: outputs hold, sequence unchanged once gaps are removed
        apply(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            re = $urandom_range(0, 1);
            apply(0, 0, re[0], 0, 0, 0, 0);
            if (re == 1) got.push_back(int'(oRand[3:0]));
        end
        check("gaps_len_ok", got.size() >= 8, 1);
        for (int i = 0; i < 8 && i < got.size(); i++) check("gaps_seq", got[i], seq0[i]);

        // Write during advance uses the old entry; later advance through k=1 uses the new one
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 1, 3);
        check("wr_same_cycle_old", oRand[3:0], 12);
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        check("wr_n3_step", oRand[3:0], 6);
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        check("wr_new_entry", oRand[3:0], 13);

        // Clear beats enable; reset beats a write and restores the default table
        apply(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 1, 1, 0, 0, 0, 0);
        check("clr_idx", oIdx, 0);
        check("clr_rand", oRand, 0);
        check("clr_nowrap", oWrap, 0);
        apply(0, 0, 0, 1, 0, 0, 5);
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 0, 7);
        apply(0, 0, 1, 0, 0, 0, 0);
        check("rst_default_x1", oRand[3:0], 8);
        apply(0, 0, 1, 0, 0, 0, 0);
        check("rst_default_x2", oRand[3:0], 12);

        // Random mix of clears, enables, writes and occasional resets
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 63) == 0) ? 1 : 0;
            rc = ($urandom_range(0, 15) == 0) ? 1 : 0;
            re = $urandom_range(0, 3) != 0 ? 1 : 0;
            rw = ($urandom_range(0, 3) == 0) ? 1 : 0;
            apply(rr[0], rc[0], re[0], rw[0], $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15));
        end
        apply(0, 0, 0, 0, 0, 0, 0);

        // Wide instance: 12-bit samples, three channels, full 4096-step period
        for (int c = 0; c < BNCH; c++)
            for (int j = 0; j < BBW; j++) bdv[c][j] = 1 << (BBW - 1 - j);
        bdrive(1, 0, 0, 0, 0, 0);
        check("big_rst_rand", b_rand, 0);
        check("big_rst_idx", b_oidx, 0);
        for (int j = 0; j < BBW; j++) bdrive(0, 0, 1, 2, j, $urandom_range(1, 4095));
        bdrive(0, 0, 1, 3, 0, $urandom_range(1, 4095));
        bdrive(0, 0, 1, 0, 13, $urandom_range(1, 4095));
        check("big_wr_hold", b_rand, 0);
        wraps = 0;
        for (int s = 1; s <= 4096; s++) begin
            bdrive(0, 1, 0, 0, 0, 0);
            if (b_wrap) wraps++;
            check("big_idx", b_oidx, s % 4096);
            check("big_wrap", b_wrap, (s == 4096) ? 1 : 0);
            for (int c = 0; c < BNCH; c++) check("big_rand", b_rand[c*BBW +: BBW], gx(c, s % 4096));
        end
        check("big_wrap_count", wraps, 1);
        bdrive(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
